// File: rtl/memory_responder_if.sv
// memory_responder_if: MAR/MDR memory strobe bundle between the control
// datapath (master) and the memory responder (slave).
//   Read, Write   - level strobes held by control for the whole access
//   Address       - word address (MAR low bits)
//   DataIn        - write data (MDR contents)
//   Mdatain       - registered read data back to the MDR input mux
//   MemDone       - one-cycle completion pulse
//   BadReq        - one-cycle pulse on a Read+Write request
interface memory_responder_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  Read;
  logic                  Write;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  MemDone;
  logic                  BadReq;

  modport master (
    output Read, Write, Address, DataIn,
    input  Mdatain, MemDone, BadReq
  );

  modport slave (
    input  Read, Write, Address, DataIn,
    output Mdatain, MemDone, BadReq
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: word-addressed RAM answering the datapath's memory
// strobes with WAIT_CYCLES wait states and a one-cycle MemDone pulse.
// Ports:
//   Clock - rising-edge clock
//   Clear - synchronous active-high reset (memory contents are kept)
//   bus   - memory_responder_if.slave (Read, Write, Address, DataIn in;
//           Mdatain, MemDone, BadReq out)
module memory_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 Clock,
  input  logic                 Clear,
  memory_responder_if.slave    bus
);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("memory_responder: WAIT_CYCLES must be at least 1");
    end
  endgenerate

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  is_wr_q;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic accept;
  logic last;

  // A request is taken only with exactly one strobe high in IDLE.
  assign accept = (state == IDLE) && (bus.Read ^ bus.Write);
  assign last   = (state == WAIT) && (cnt == CNT_LAST);

  // Request capture: latched once at acceptance so strobe/address changes
  // during WAIT are ignored.
  always_ff @(posedge Clock) begin
    if (!Clear && accept) begin
      addr_q  <= bus.Address;
      data_q  <= bus.DataIn;
      is_wr_q <= bus.Write;
    end
  end

  // Array write on the completing edge; Clear in WAIT aborts it.
  always_ff @(posedge Clock) begin
    if (!Clear && last && is_wr_q) begin
      mem[addr_q] <= data_q;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.Mdatain <= '0;
      bus.MemDone <= 1'b0;
      bus.BadReq  <= 1'b0;
    end else begin
      bus.MemDone <= 1'b0;
      bus.BadReq  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Read && bus.Write) begin
            bus.BadReq <= 1'b1;
            state      <= HOLD;
          end else if (accept) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            bus.MemDone <= 1'b1;
            state       <= DONE;
            if (!is_wr_q) begin
              bus.Mdatain <= mem[addr_q];
            end
          end
        end
        DONE: begin
          // Strobe still held means control has not left its state yet.
          state <= (bus.Read || bus.Write) ? HOLD : IDLE;
        end
        HOLD: begin
          if (!bus.Read && !bus.Write) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: drives two responders (WAIT_CYCLES=1 and 3) through
// directed vectors, multi-cycle corner sequences and randomized accesses
// checked against a transaction-level memory model.
module tb_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        clr;
  logic [1:0]        rd, wr;
  logic [1:0][8:0]   addr;
  logic [1:0][31:0]  din;
  logic [1:0][31:0]  md;
  logic [1:0]        done, bad;

  int errors = 0;
  int checks = 0;

  memory_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if1 ();
  memory_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if3 ();

  assign if1.Read    = rd[0];
  assign if1.Write   = wr[0];
  assign if1.Address = addr[0];
  assign if1.DataIn  = din[0];
  assign md[0]       = if1.Mdatain;
  assign done[0]     = if1.MemDone;
  assign bad[0]      = if1.BadReq;

  assign if3.Read    = rd[1];
  assign if3.Write   = wr[1];
  assign if3.Address = addr[1];
  assign if3.DataIn  = din[1];
  assign md[1]       = if3.Mdatain;
  assign done[1]     = if3.MemDone;
  assign bad[1]      = if3.BadReq;

  memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(1)) dut1 (
    .Clock (clk),
    .Clear (clr[0]),
    .bus   (if1.slave)
  );

  memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(3)) dut3 (
    .Clock (clk),
    .Clear (clr[1]),
    .bus   (if3.slave)
  );

  function automatic int wcyc(int sel);
    return (sel != 0) ? 3 : 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called from the falling edge; returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete access: strobe held for the minimum time plus 'hold'
  // extra edges, then released and the FSM allowed back to IDLE.
  task automatic do_access(int sel, bit is_wr, logic [8:0] a, logic [31:0] d,
                           int hold, logic [31:0] exp_md);
    int pulses = 0;
    int first  = -1;
    int bads   = 0;
    addr[sel] = a;
    din[sel]  = d;
    if (is_wr) wr[sel] = 1'b1;
    else       rd[sel] = 1'b1;
    for (int k = 1; k <= wcyc(sel) + 1 + hold; k++) begin
      tick();
      if (done[sel]) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (bad[sel]) bads++;
    end
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
    tick();
    chk($sformatf("done_pulses[%0d]", sel), pulses, 1);
    // Edge 1 is acceptance; MemDone follows WAIT_CYCLES edges later.
    chk($sformatf("done_latency[%0d]", sel), first, wcyc(sel) + 1);
    chk($sformatf("no_badreq[%0d]", sel), bads, 0);
    chk($sformatf("mdatain[%0d] a=%h", sel, a), md[sel], exp_md);
  endtask

  typedef struct {
    bit          is_wr;
    logic [8:0]  a;
    logic [31:0] d;
    int          hold;
    logic [31:0] exp_md;
  } vec_t;

  vec_t vecs[7];

  logic [31:0] model_mem [512];
  logic [8:0]  written [$];
  logic [31:0] model_md;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first;

    vecs[0] = '{1'b1, 9'h012, 32'h4A92_0000, 0, 32'h0000_0055};
    vecs[1] = '{1'b0, 9'h012, 32'h0,         0, 32'h4A92_0000};
    vecs[2] = '{1'b1, 9'h024, 32'h0000_0024, 0, 32'h4A92_0000};
    vecs[3] = '{1'b0, 9'h024, 32'h0,         4, 32'h0000_0024};
    vecs[4] = '{1'b1, 9'h005, 32'h0000_0011, 0, 32'h0000_0024};
    vecs[5] = '{1'b1, 9'h022, 32'h0000_0022, 0, 32'h0000_0024};
    vecs[6] = '{1'b0, 9'h022, 32'h0,         1, 32'h0000_0022};

    clr  = 2'b11;
    rd   = '0;
    wr   = '0;
    addr = '0;
    din  = '0;
    @(negedge clk);
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_mdatain[%0d]", s), md[s], 0);
      chk($sformatf("rst_memdone[%0d]", s), done[s], 0);
      chk($sformatf("rst_badreq[%0d]", s), bad[s], 0);
    end
    clr = 2'b00;

    // Seed a word so the post-reset read has a known value.
    do_access(0, 1'b1, 9'h0AA, 32'h0000_0055, 0, 32'h0);

    // Clear held two cycles with Read high: no access until release.
    clr[0]  = 1'b1;
    rd[0]   = 1'b1;
    addr[0] = 9'h0AA;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("clr_memdone", done[0], 0);
      chk("clr_badreq", bad[0], 0);
      chk("clr_mdatain", md[0], 0);
    end
    clr[0] = 1'b0;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (done[0]) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    rd[0] = 1'b0;
    tick();
    chk("post_clr_pulses", pulses, 1);
    chk("post_clr_latency", first, 2);
    chk("post_clr_data", md[0], 32'h0000_0055);

    for (int i = 0; i < 7; i++) begin
      do_access(0, vecs[i].is_wr, vecs[i].a, vecs[i].d, vecs[i].hold,
                vecs[i].exp_md);
    end

    // Illegal Read+Write: BadReq once, then stuck in HOLD until both drop.
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    addr[0] = 9'h024;
    din[0]  = 32'hFFFF_FFFF;
    tick();
    chk("bad_pulse", bad[0], 1);
    chk("bad_no_done", done[0], 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bad_once", bad[0], 0);
    end
    wr[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done[0] || bad[0]) pulses++;
    end
    chk("hold_read_ignored", pulses, 0);
    chk("bad_mdatain_kept", md[0], 32'h0000_0022);
    rd[0] = 1'b0;
    tick();
    do_access(0, 1'b0, 9'h024, 32'h0, 0, 32'h0000_0024);
    do_access(0, 1'b0, 9'h022, 32'h0, 0, 32'h0000_0022);

    // Clear during WAIT aborts a pending write.
    addr[0] = 9'h005;
    din[0]  = 32'hDEAD_BEEF;
    wr[0]   = 1'b1;
    tick();
    clr[0] = 1'b1;
    tick();
    chk("abort_mdatain", md[0], 0);
    chk("abort_memdone", done[0], 0);
    clr[0] = 1'b0;
    wr[0]  = 1'b0;
    tick();
    do_access(0, 1'b0, 9'h005, 32'h0, 0, 32'h0000_0011);

    // WAIT_CYCLES=3: address moved to 0x000 during WAIT must be ignored.
    do_access(1, 1'b1, 9'h1FF, 32'h0000_0026, 0, 32'h0);
    rd[1]   = 1'b1;
    addr[1] = 9'h1FF;
    pulses  = 0;
    first   = -1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) addr[1] = 9'h000;
      if (done[1]) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    rd[1] = 1'b0;
    tick();
    chk("w3_pulses", pulses, 1);
    chk("w3_latency", first, 4);
    chk("w3_data", md[1], 32'h0000_0026);

    // Randomized accesses against a word-array model: reads only target
    // words written in this phase, the read register follows the last read.
    for (int s = 0; s < 2; s++) begin
      written.delete();
      model_md = (s == 0) ? 32'h0000_0011 : 32'h0000_0026;
      for (int i = 0; i < 30; i++) begin
        logic [8:0]  a;
        logic [31:0] d;
        bit          is_wr;
        is_wr = (written.size() == 0) || ($urandom_range(1) == 0);
        if (is_wr) begin
          a = 9'($urandom_range(511));
          d = $urandom;
          model_mem[a] = d;
          written.push_back(a);
        end else begin
          a = written[$urandom_range(written.size() - 1)];
          d = $urandom;
          model_md = model_mem[a];
        end
        do_access(s, is_wr, a, d, $urandom_range(2), model_md);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
